// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared definitions for the data-cache tag/valid maintenance
//                logic: maintenance op encodings, cache geometry and the
//                maintenance controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam int NUM_WAYS   = 4;
    localparam int INDEX_W    = 6;
    localparam int TAG_W      = 20;
    localparam int LINE_OFF_W = 6;
    localparam int ADDR_W     = 32;

    // Maintenance op encodings carried on req_op
    localparam logic [1:0] OP_SWEEP_ALL = 2'b00;
    localparam logic [1:0] OP_INDEX_INV = 2'b01;
    localparam logic [1:0] OP_HIT_INV   = 2'b10;
    localparam logic [1:0] OP_RESERVED  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SWEEP  = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tagv_maint_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tagv_maint_ctrl
//  Description : Tag/valid maintenance controller. Accepts one maintenance
//                request at a time and issues the matching invalidation
//                writes to the tag/valid memory:
//                  00 sweep-all        : clear every way of every set
//                  01 index-invalidate : clear one way at the request index
//                  10 hit-invalidate   : look up the address, clear hit ways
//                  11 reserved         : accepted, completes with no write
//  Ports       : clk, rstn (async, active-low)
//                req_valid/req_ready/req_op/req_addr/req_way : request
//                r_addr/lookup_tag/hit                       : lookup port
//                w_addr/we/tagv_clear                        : write port
//                busy/done                                   : status
//  Config      : `define TAGV_SWEEP_ON_RESET_EN makes reset exit perform a
//                full sweep (ending in a done pulse) before the first request
//                can be accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module tagv_maint_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_SETS = 64
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [1:0]          req_way,
    output logic [ADDR_W-1:0]   r_addr,
    output logic [TAG_W-1:0]    lookup_tag,
    input  logic [NUM_WAYS-1:0] hit,
    output logic [ADDR_W-1:0]   w_addr,
    output logic [NUM_WAYS-1:0] we,
    output logic                tagv_clear,
    output logic                busy,
    output logic                done
);

    localparam logic [INDEX_W-1:0] C_LAST_IDX = INDEX_W'(NUM_SETS - 1);
    localparam int                 C_HI_PAD   = ADDR_W - INDEX_W - LINE_OFF_W;

`ifdef TAGV_SWEEP_ON_RESET_EN
    localparam state_t C_RESET_STATE = ST_SWEEP;
`else
    localparam state_t C_RESET_STATE = ST_IDLE;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [INDEX_W-1:0]  r_idx;
    logic [ADDR_W-1:0]   r_req_addr;
    logic [1:0]          r_req_op;
    logic [1:0]          r_req_way;

    logic                w_accept;
    logic                w_sweep_last;
    logic                w_out_en;
    logic [NUM_WAYS-1:0] w_way_onehot;
    logic [NUM_WAYS-1:0] w_we;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [TAG_W-1:0]    w_tag;

`ifdef TAGV_SWEEP_ON_RESET_EN
    // The reset state is SWEEP, so keep the status and write port quiet
    // while reset is held; the sweep only starts driving after release.
    assign w_out_en = rstn;
`else
    assign w_out_en = 1'b1;
`endif

    assign w_accept     = req_valid && (r_state == ST_IDLE);
    assign w_sweep_last = (r_idx == C_LAST_IDX);
    assign w_way_onehot = NUM_WAYS'(1) << r_req_way;

    // ------------------------------------------------------------------
    // State register, sweep counter and request latches
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= C_RESET_STATE;
            r_idx      <= '0;
            r_req_addr <= '0;
            r_req_op   <= OP_SWEEP_ALL;
            r_req_way  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_req_addr <= req_addr;
                r_req_op   <= req_op;
                r_req_way  <= req_way;
                r_idx      <= '0;
            end else if ((r_state == ST_SWEEP) && !w_sweep_last) begin
                r_idx <= r_idx + INDEX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and write/lookup port decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_we        = '0;
        w_wr_addr   = '0;
        w_rd_addr   = '0;
        w_tag       = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (req_op)
                        OP_SWEEP_ALL: w_state_nxt = ST_SWEEP;
                        OP_HIT_INV:   w_state_nxt = ST_LOOKUP;
                        default:      w_state_nxt = ST_DONE;
                    endcase
                end
            end
            ST_SWEEP: begin
                w_we      = '1;
                w_wr_addr = {{C_HI_PAD{1'b0}}, r_idx, {LINE_OFF_W{1'b0}}};
                if (w_sweep_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_LOOKUP: begin
                w_rd_addr   = r_req_addr;
                w_tag       = r_req_addr[ADDR_W-1 -: TAG_W];
                w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                // hit returns one cycle after the lookup; zero hits => no write
                w_we        = hit;
                w_wr_addr   = r_req_addr;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // Index-invalidate goes straight from accept to DONE, so its
                // single write lands in this cycle alongside the done pulse.
                if (r_req_op == OP_INDEX_INV) begin
                    w_we      = w_way_onehot;
                    w_wr_addr = r_req_addr;
                end
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign req_ready  = (r_state == ST_IDLE) && w_out_en;
    assign busy       = (r_state != ST_IDLE) && w_out_en;
    assign done       = (r_state == ST_DONE) && w_out_en;
    assign we         = w_out_en ? w_we : '0;
    assign tagv_clear = |we;
    assign w_addr     = (|we) ? w_wr_addr : '0;
    assign r_addr     = w_rd_addr;
    assign lookup_tag = w_tag;

endmodule
`default_nettype wire

// File: tb/tb_tagv_maint_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tagv_maint_ctrl
//  Description : Directed self-checking bench for tagv_maint_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tagv_maint_ctrl;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [1:0]  req_way;
    logic [31:0] r_addr;
    logic [19:0] lookup_tag;
    logic [3:0]  hit;
    logic [31:0] w_addr;
    logic [3:0]  we;
    logic        tagv_clear;
    logic        busy;
    logic        done;

    int total;
    int bad;

    tagv_maint_ctrl #(.NUM_SETS(64)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_way    (req_way),
        .r_addr     (r_addr),
        .lookup_tag (lookup_tag),
        .hit        (hit),
        .w_addr     (w_addr),
        .we         (we),
        .tagv_clear (tagv_clear),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one cycle; observe 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects to be called in the first sweep cycle (idx 0 on the bus).
    // Leaves the bench in the cycle after done (idle).
    task automatic check_sweep(input string name);
        logic [31:0] exp_addr;
        for (int i = 0; i < 64; i++) begin
            exp_addr = 32'(i) << 6;
            total++;
            if (we !== 4'hF || tagv_clear !== 1'b1 || w_addr !== exp_addr ||
                busy !== 1'b1 || done !== 1'b0 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s idx%0d: we=%h clr=%b w_addr=%h busy=%b done=%b rdy=%b, want we=f clr=1 w_addr=%h busy=1 done=0 rdy=0",
                         name, i, we, tagv_clear, w_addr, busy, done, req_ready, exp_addr);
            end
            tick();
        end
        total++;
        if (done !== 1'b1 || we !== 4'h0 || tagv_clear !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s done cycle: done=%b we=%h clr=%b busy=%b, want done=1 we=0 clr=0 busy=1",
                     name, done, we, tagv_clear, busy);
        end
        tick();
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || we !== 4'h0) begin
            bad++;
            $display("FAIL %s back to idle: rdy=%b busy=%b done=%b we=%h, want rdy=1 busy=0 done=0 we=0",
                     name, req_ready, busy, done, we);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_way = '0; hit = '0;
        tick();
        tick();
        total++;
        if (we !== 4'h0 || tagv_clear !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
            r_addr !== 32'h0 || w_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_values: we=%h clr=%b done=%b busy=%b r_addr=%h w_addr=%h, want all zero",
                     we, tagv_clear, done, busy, r_addr, w_addr);
        end
        rstn = 1'b1;
        #1;
`ifdef TAGV_SWEEP_ON_RESET_EN
        total++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_exit: busy=%b rdy=%b, want busy=1 rdy=0", busy, req_ready);
        end
        check_sweep("boot_sweep");
`else
        total++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_exit: busy=%b rdy=%b, want busy=0 rdy=1", busy, req_ready);
        end
        tick();
`endif
    endtask

    task automatic test_sweep();
        req_valid = 1'b1; req_op = 2'b00; req_addr = 32'hFFFF_FFC0;
        total++;
        if (req_ready !== 1'b1 || we !== 4'h0) begin
            bad++;
            $display("FAIL sweep_accept: rdy=%b we=%h, want rdy=1 we=0", req_ready, we);
        end
        tick();
        req_valid = 1'b0;
        check_sweep("sweep");
    endtask

    task automatic test_index_inv();
        req_valid = 1'b1; req_op = 2'b01; req_addr = 32'h1234_5A40; req_way = 2'd2;
        total++;
        if (we !== 4'h0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL idx_accept: we=%h rdy=%b, want we=0 rdy=1", we, req_ready);
        end
        tick();
        // change inputs and keep req_valid high while busy
        req_addr = 32'hDEAD_BEEF; req_way = 2'd0; req_op = 2'b00;
        #1;
        total++;
        if (we !== 4'b0100 || w_addr !== 32'h1234_5A40 || tagv_clear !== 1'b1 ||
            done !== 1'b1 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL idx_write: we=%h w_addr=%h clr=%b done=%b rdy=%b, want we=4 w_addr=12345a40 clr=1 done=1 rdy=0",
                     we, w_addr, tagv_clear, done, req_ready);
        end
        tick();
        req_valid = 1'b0;
        #1;
        total++;
        if (we !== 4'h0 || done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idx_after: we=%h done=%b rdy=%b busy=%b, want we=0 done=0 rdy=1 busy=0",
                     we, done, req_ready, busy);
        end
        tick();
        total++;
        if (busy !== 1'b0 || we !== 4'h0) begin
            bad++;
            $display("FAIL idx_no_reaccept: busy=%b we=%h, want busy=0 we=0", busy, we);
        end
    endtask

    task automatic test_hit_inv(input logic [31:0] addr, input logic [3:0] h);
        logic [3:0] exp_we;
        exp_we = h;
        req_valid = 1'b1; req_op = 2'b10; req_addr = addr;
        tick();
        req_valid = 1'b1; req_op = 2'b01; req_addr = 32'h0BAD_0BAD; req_way = 2'd3;
        #1;
        total++;
        if (r_addr !== addr || lookup_tag !== addr[31:12] || we !== 4'h0 ||
            busy !== 1'b1 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL hit_lookup: r_addr=%h tag=%h we=%h busy=%b rdy=%b, want r_addr=%h tag=%h we=0 busy=1 rdy=0",
                     r_addr, lookup_tag, we, busy, req_ready, addr, addr[31:12]);
        end
        tick();
        hit = h;
        #1;
        total++;
        if (we !== exp_we || tagv_clear !== (exp_we != 4'h0) ||
            (exp_we != 4'h0 && w_addr !== addr) || done !== 1'b0) begin
            bad++;
            $display("FAIL hit_check: we=%h clr=%b w_addr=%h done=%b, want we=%h clr=%b w_addr=%h done=0",
                     we, tagv_clear, w_addr, done, exp_we, exp_we != 4'h0, addr);
        end
        tick();
        hit = 4'h0;
        req_valid = 1'b0;
        #1;
        total++;
        if (done !== 1'b1 || we !== 4'h0 || tagv_clear !== 1'b0) begin
            bad++;
            $display("FAIL hit_done: done=%b we=%h clr=%b, want done=1 we=0 clr=0", done, we, tagv_clear);
        end
        tick();
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL hit_idle: rdy=%b busy=%b, want rdy=1 busy=0", req_ready, busy);
        end
    endtask

    task automatic test_reserved();
        req_valid = 1'b1; req_op = 2'b11; req_addr = 32'h0000_1040; req_way = 2'd1;
        tick();
        req_valid = 1'b0;
        total++;
        if (done !== 1'b1 || we !== 4'h0 || tagv_clear !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reserved_done: done=%b we=%h clr=%b busy=%b, want done=1 we=0 clr=0 busy=1",
                     done, we, tagv_clear, busy);
        end
        tick();
        total++;
        if (req_ready !== 1'b1 || we !== 4'h0) begin
            bad++;
            $display("FAIL reserved_idle: rdy=%b we=%h, want rdy=1 we=0", req_ready, we);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int writes;
        int dones;
        req_valid = 1'b1; req_op = 2'b00;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        total++;
        if (we !== 4'hF || w_addr !== (32'd20 << 6)) begin
            bad++;
            $display("FAIL abort_pre: we=%h w_addr=%h, want we=f w_addr=%h", we, w_addr, 32'd20 << 6);
        end
        rstn = 1'b0;
        #1;
        total++;
        if (we !== 4'h0 || tagv_clear !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || w_addr !== 32'h0) begin
            bad++;
            $display("FAIL abort_immediate: we=%h clr=%b busy=%b done=%b w_addr=%h, want all zero",
                     we, tagv_clear, busy, done, w_addr);
        end
        writes = 0;
        dones  = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (we !== 4'h0) writes++;
            if (done !== 1'b0) dones++;
        end
        total++;
        if (writes != 0 || dones != 0) begin
            bad++;
            $display("FAIL abort_quiet: writes=%0d dones=%0d, want 0 0", writes, dones);
        end
        rstn = 1'b1;
        #1;
`ifdef TAGV_SWEEP_ON_RESET_EN
        check_sweep("restart_sweep");
`else
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || we !== 4'h0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_release: rdy=%b busy=%b we=%h done=%b, want rdy=1 busy=0 we=0 done=0",
                     req_ready, busy, we, done);
        end
        tick();
        req_valid = 1'b1; req_op = 2'b01; req_addr = 32'h0000_0FC0; req_way = 2'd3;
        tick();
        req_valid = 1'b0;
        total++;
        if (we !== 4'b1000 || w_addr !== 32'h0000_0FC0 || done !== 1'b1) begin
            bad++;
            $display("FAIL abort_new_req: we=%h w_addr=%h done=%b, want we=8 w_addr=00000fc0 done=1",
                     we, w_addr, done);
        end
        tick();
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_sweep();
        test_index_inv();
        test_hit_inv(32'hABCD_E7C0, 4'b1001);
        test_hit_inv(32'h5555_5040, 4'b0000);
        test_hit_inv(32'h0000_3000, 4'b0110);
        test_reserved();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
